// File: rtl/uart_wb_host_pkg.sv
// Shared types and constants for the UART-to-Wishbone host bridge.
package uart_wb_host_pkg;

  typedef enum logic [2:0] {
    eUartWbHostState_Idle,
    eUartWbHostState_GetData,
    eUartWbHostState_Bus,
    eUartWbHostState_SendStatus,
    eUartWbHostState_SendData
  } uart_wb_host_state_e;

  localparam logic [7:0] STATUS_OK      = 8'h00;
  localparam logic [7:0] STATUS_TIMEOUT = 8'h01;
  localparam logic [7:0] STATUS_BADCMD  = 8'h02;

  // Controller-side Wishbone signals driven by the host.
  typedef struct packed {
    logic       stb;
    logic       we;
    logic [3:0] adr;
    logic [7:0] dat;
  } wb_ctrl_t;

  // Peripheral-side Wishbone signals returned to the host.
  typedef struct packed {
    logic       ack;
    logic [7:0] dat;
  } wb_peri_t;

  // A command byte is well-formed only when its reserved bits 6:4 are zero.
  function automatic logic cmd_is_valid(input logic [7:0] cmd);
    return (cmd[6:4] == 3'b000);
  endfunction

endpackage

// File: rtl/uart_wb_host.sv
// UART byte stream to single Wishbone access bridge.
// Command byte: bit7 = we, bits6:4 reserved (0), bits3:0 = adr.
// A write command is followed by one data byte. Every command is answered
// with a status byte; reads additionally return the data byte.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// Idle       | waiting for a command byte
// GetData    | write command seen, waiting for the data byte
// Bus        | stb asserted, waiting for ack or timeout
// SendStatus | offering the status byte on tx
// SendData   | offering the read data byte on tx
module uart_wb_host
  import uart_wb_host_pkg::*;
#(
  parameter int pTimeoutCycles = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output wb_ctrl_t   wb_c,
  input  wb_peri_t   wb_p,
  output logic       rx_overrun
);

  // Last counter value of an unanswered access; stb is high for cnt = 0..this.
  localparam logic [15:0] TIMEOUT_LAST = 16'(pTimeoutCycles - 1);

  uart_wb_host_state_e state;
  logic [1:0]          rst_sync;
  logic                rst_int;
  logic                stb;
  logic                we;
  logic [3:0]          adr;
  logic [7:0]          dat;
  logic [7:0]          rd_data;
  logic [15:0]         cnt;

  // Reset asserts asynchronously and releases two clk edges later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int = rst_sync[1];

  // Command parsing, bus access, timeout and response sequencing.
  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) begin
      state      <= eUartWbHostState_Idle;
      stb        <= 1'b0;
      we         <= 1'b0;
      adr        <= 4'h0;
      dat        <= 8'h00;
      rd_data    <= 8'h00;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      rx_overrun <= 1'b0;
      cnt        <= 16'h0000;
    end else begin
      case (state)
        eUartWbHostState_Idle: begin
          if (rx_valid) begin
            if (!cmd_is_valid(rx_data)) begin
              tx_data  <= STATUS_BADCMD;
              tx_valid <= 1'b1;
              state    <= eUartWbHostState_SendStatus;
            end else begin
              we  <= rx_data[7];
              adr <= rx_data[3:0];
              if (rx_data[7]) begin
                state <= eUartWbHostState_GetData;
              end else begin
                dat   <= 8'h00;
                stb   <= 1'b1;
                cnt   <= 16'h0000;
                state <= eUartWbHostState_Bus;
              end
            end
          end
        end

        eUartWbHostState_GetData: begin
          if (rx_valid) begin
            dat   <= rx_data;
            stb   <= 1'b1;
            cnt   <= 16'h0000;
            state <= eUartWbHostState_Bus;
          end
        end

        eUartWbHostState_Bus: begin
          if (rx_valid) rx_overrun <= 1'b1;
          // ack wins over a timeout expiring in the same cycle
          if (wb_p.ack) begin
            stb      <= 1'b0;
            tx_data  <= STATUS_OK;
            tx_valid <= 1'b1;
            if (!we) rd_data <= wb_p.dat;
            state    <= eUartWbHostState_SendStatus;
          end else if (cnt == TIMEOUT_LAST) begin
            stb      <= 1'b0;
            tx_data  <= STATUS_TIMEOUT;
            tx_valid <= 1'b1;
            rd_data  <= 8'h00;
            state    <= eUartWbHostState_SendStatus;
          end else if (cnt != 16'hFFFF) begin
            cnt <= cnt + 16'h0001;
          end
        end

        eUartWbHostState_SendStatus: begin
          if (rx_valid) rx_overrun <= 1'b1;
          if (tx_ready) begin
            // we may be stale after a bad command, so the status byte decides
            if (!we && (tx_data != STATUS_BADCMD)) begin
              tx_data <= rd_data;
              state   <= eUartWbHostState_SendData;
            end else begin
              tx_valid <= 1'b0;
              state    <= eUartWbHostState_Idle;
            end
          end
        end

        eUartWbHostState_SendData: begin
          if (rx_valid) rx_overrun <= 1'b1;
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= eUartWbHostState_Idle;
          end
        end

        default: state <= eUartWbHostState_Idle;
      endcase
    end
  end

  assign wb_c = '{stb: stb, we: we, adr: adr, dat: dat};

endmodule

// File: tb/tb_uart_wb_host.sv
// Self-checking bench for uart_wb_host with a transaction-level model.
module tb_uart_wb_host;
  import uart_wb_host_pkg::*;

  localparam int T = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready = 1'b1;
  wb_ctrl_t   wb_c;
  wb_peri_t   wb_p = '0;
  logic       rx_overrun;

  uart_wb_host #(.pTimeoutCycles(T)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .wb_c(wb_c), .wb_p(wb_p), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [3:0] adr;
    logic [7:0] dat;
    bit         chk_dat;
    int         len;
  } acc_t;

  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] got_tx[$];
  acc_t       exp_acc[$];
  logic       exp_ovr = 1'b0;
  int         ack_delay = 0;
  logic [7:0] ack_dat = 8'h00;
  int         last_len = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic fail_event(input string name, input logic [31:0] got);
    n_checks++;
    $display("FAIL %s: got %0h, expected none", name, got);
  endtask

  // Peripheral: acks during the ack_delay-th cycle of stb (0 = never).
  int stb_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (!rst || !wb_c.stb) begin
      stb_cnt    = 0;
      wb_p.ack   = 1'b0;
    end else begin
      stb_cnt++;
      wb_p.ack = (stb_cnt == ack_delay);
      wb_p.dat = ack_dat;
    end
  end

  // Compare process: tx handshakes, tx hold, wb access shape, overrun flag.
  logic       prev_stb = 1'b0, prev_txv = 1'b0, prev_txr = 1'b0;
  logic [7:0] prev_txd = 8'h00;
  bit         in_acc = 1'b0;
  acc_t       cur;
  logic [7:0] seen_dat;
  int         stb_len = 0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_stb = 1'b0; prev_txv = 1'b0; prev_txr = 1'b0; in_acc = 1'b0;
    end else begin
      check("rx_overrun", rx_overrun, exp_ovr);
      if (prev_txv && !prev_txr) begin
        check("tx_hold_valid", tx_valid, 1'b1);
        check("tx_hold_data", tx_data, prev_txd);
      end
      if (tx_valid && tx_ready) begin
        got_tx.push_back(tx_data);
        if (exp_tx.size() == 0) fail_event("unexpected_tx", tx_data);
        else check("tx_byte", tx_data, exp_tx.pop_front());
      end
      if (wb_c.stb && !prev_stb) begin
        if (exp_acc.size() == 0) begin
          fail_event("unexpected_stb", wb_c.adr);
          in_acc = 1'b0;
        end else begin
          cur = exp_acc.pop_front();
          check("wb_we", wb_c.we, cur.we);
          check("wb_adr", wb_c.adr, cur.adr);
          if (cur.chk_dat) check("wb_dat", wb_c.dat, cur.dat);
          seen_dat = wb_c.dat;
          in_acc   = 1'b1;
        end
        stb_len = 1;
      end else if (wb_c.stb) begin
        stb_len++;
        if (in_acc) begin
          check("wb_we_stable", wb_c.we, cur.we);
          check("wb_adr_stable", wb_c.adr, cur.adr);
          check("wb_dat_stable", wb_c.dat, seen_dat);
        end
      end else if (prev_stb && in_acc) begin
        check("stb_len", stb_len, cur.len);
        last_len = stb_len;
        in_acc   = 1'b0;
      end
      prev_stb = wb_c.stb; prev_txv = tx_valid; prev_txr = tx_ready; prev_txd = tx_data;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // Model: what one command must produce on the bus and on tx.
  task automatic model_txn(input logic [7:0] cmd, input logic [7:0] data);
    acc_t a;
    bit   acked;
    if (cmd[6:4] != 3'b000) begin
      exp_tx.push_back(8'h02);
    end else begin
      acked     = (ack_delay >= 1) && (ack_delay <= T);
      a.we      = cmd[7];
      a.adr     = cmd[3:0];
      a.dat     = data;
      a.chk_dat = cmd[7];
      a.len     = acked ? ack_delay : T;
      exp_acc.push_back(a);
      exp_tx.push_back(acked ? 8'h00 : 8'h01);
      if (!cmd[7]) exp_tx.push_back(acked ? ack_dat : 8'h00);
    end
  endtask

  task automatic run_txn(input logic [7:0] cmd, input logic [7:0] data, input int dly,
                         input logic [7:0] adat, input bit ovr, input bit stall);
    int n;
    ack_delay = dly; ack_dat = adat;
    got_tx.delete();
    model_txn(cmd, data);
    if (stall) tx_ready = 1'b0;
    @(posedge clk); #1;
    send_byte(cmd);
    if (cmd[7] && cmd[6:4] == 3'b000) send_byte(data);
    if (ovr) begin
      n = 0;
      while (!wb_c.stb && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) fail_event("wait_stb_timeout", n);
      send_byte(8'hEE);
      exp_ovr = 1'b1;
    end
    if (stall) begin
      n = 0;
      while (!tx_valid && n < 100) begin @(posedge clk); #1; n++; end
      if (n >= 100) fail_event("wait_tx_timeout", n);
      repeat (5) @(posedge clk);
      #1 tx_ready = 1'b1;
    end
    n = 0;
    while ((exp_tx.size() != 0 || exp_acc.size() != 0 || wb_c.stb || tx_valid) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) fail_event("txn_done_timeout", n);
    repeat (2) @(posedge clk);
  endtask

  task automatic expect_bytes(input string name, input int n, input logic [7:0] b0, input logic [7:0] b1);
    check({name, "_count"}, got_tx.size(), n);
    if (n > 0 && got_tx.size() > 0) check({name, "_b0"}, got_tx[0], b0);
    if (n > 1 && got_tx.size() > 1) check({name, "_b1"}, got_tx[1], b1);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stb", wb_c.stb, 1'b0);
    check("rst_we", wb_c.we, 1'b0);
    check("rst_adr", wb_c.adr, 4'h0);
    check("rst_dat", wb_c.dat, 8'h00);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_overrun", rx_overrun, 1'b0);
    rst = 1'b1;
    repeat (4) @(posedge clk);

    run_txn(8'h83, 8'h5A, 3, 8'h00, 0, 0);
    expect_bytes("wr_ack", 1, 8'h00, 8'h00);
    check("wr_ack_len", last_len, 3);

    run_txn(8'h07, 8'h00, 2, 8'hC4, 0, 0);
    expect_bytes("rd_ack", 2, 8'h00, 8'hC4);

    run_txn(8'h02, 8'h00, 0, 8'h77, 0, 0);
    expect_bytes("rd_timeout", 2, 8'h01, 8'h00);
    check("rd_timeout_len", last_len, 8);

    run_txn(8'h30, 8'h00, 1, 8'h00, 0, 0);
    expect_bytes("bad_cmd", 1, 8'h02, 8'h00);

    run_txn(8'h0F, 8'h00, T, 8'h3C, 0, 0);
    expect_bytes("ack_at_timeout", 2, 8'h00, 8'h3C);
    check("ack_at_timeout_len", last_len, 8);

    run_txn(8'h8A, 8'h11, 0, 8'h00, 0, 0);
    expect_bytes("wr_timeout", 1, 8'h01, 8'h00);

    run_txn(8'hF1, 8'h00, 1, 8'h00, 0, 0);
    expect_bytes("bad_cmd_we", 1, 8'h02, 8'h00);

    run_txn(8'h05, 8'h00, 4, 8'h99, 1, 1);
    expect_bytes("ovr_stall", 2, 8'h00, 8'h99);
    check("ovr_sticky", rx_overrun, 1'b1);

    // Reset in the middle of a bus access.
    ack_delay = 0;
    got_tx.delete();
    model_txn(8'h04, 8'h00);
    @(posedge clk); #1;
    send_byte(8'h04);
    n = 0;
    while (!wb_c.stb && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) fail_event("rst_wait_stb_timeout", n);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    exp_tx.delete(); exp_acc.delete(); exp_ovr = 1'b0;
    #1;
    check("midbus_rst_stb", wb_c.stb, 1'b0);
    check("midbus_rst_tx_valid", tx_valid, 1'b0);
    check("midbus_rst_overrun", rx_overrun, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    expect_bytes("after_rst_silent", 0, 8'h00, 8'h00);

    run_txn(8'h81, 8'hA5, 1, 8'h00, 0, 0);
    expect_bytes("after_rst_wr", 1, 8'h00, 8'h00);
    check("after_rst_len", last_len, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/uart_wb_host.md
UART_WB_HOST -- requirements
Module: uart_wb_host

Interface
REQ-001 Parameter pTimeoutCycles, default 255: cycles allowed for wb_p.ack before a bus access is aborted; legal range 1..65535.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 rx_valid  input  1  one-cycle strobe: rx_data holds a received byte.
REQ-005 rx_data  input  8  received byte.
REQ-006 tx_valid  output  1  response byte offered.
REQ-007 tx_data  output  8  response byte.
REQ-008 tx_ready  input  1  byte accepted when tx_valid & tx_ready.
REQ-009 wb_c  output  iWishbone_Ctrl  controller side; fields used: stb, we, adr[3:0], dat[7:0].
REQ-010 wb_p  input  iWishbone_Peri  peripheral side; fields used: ack, dat[7:0].
REQ-011 rx_overrun  output  1  sticky; rx byte dropped because the block was busy.

Function
REQ-012 Command byte: bit7 = we, bits6:4 = 000, bits3:0 = adr.
REQ-013 States: Idle, GetData, Bus, SendStatus, SendData.
REQ-014 Idle + rx_valid: bits6:4 != 000 -> status 0x02, go SendStatus; we=1 -> latch adr, go GetData; we=0 -> latch adr, go Bus.
REQ-015 GetData + rx_valid: latch byte as write data, go Bus.
REQ-016 Bus: wb_c.stb = 1 from the first cycle in Bus; wb_c.we, adr and dat stay stable until exit.
REQ-017 Bus + wb_p.ack: deassert stb the next cycle; status 0x00; a read latches wb_p.dat in the same cycle; go SendStatus.
REQ-018 Bus with no ack after pTimeoutCycles cycles of stb: deassert stb; status 0x01; read data is 0x00; go SendStatus.
REQ-019 An ack arriving in the same cycle the timeout expires counts as success.
REQ-020 SendStatus: tx_valid = 1, tx_data = status; on handshake, go SendData if the access was a read with status 0x00 or 0x01, otherwise go Idle.
REQ-021 SendData: tx_valid = 1, tx_data = latched read data; go Idle on handshake.
REQ-022 tx_data is stable while tx_valid = 1 and tx_ready = 0.
REQ-023 rx_valid in Bus, SendStatus or SendData: the byte is discarded and rx_overrun is set; the current transaction continues unaffected.
REQ-024 rx_overrun clears only on reset.
REQ-025 No pipelining: at most one wb access is outstanding, and stb is never asserted outside Bus.
REQ-026 The timeout counter is 16 bits, clears on Bus entry and does not wrap.

Reset
REQ-027 On reset assertion, asynchronously: state = Idle, wb_c.stb = 0, wb_c.we = 0, adr = 0, dat = 0, tx_valid = 0, tx_data = 0, rx_overrun = 0, counter = 0.
REQ-028 Reset during Bus or a send state aborts the transaction; no response byte is emitted after release.
REQ-029 Reset release is synchronised to clk before use.

Structure
REQ-030 The shared package holds the state enum (eUartWbHostState_*) and the status constants STATUS_OK = 0x00, STATUS_TIMEOUT = 0x01 and STATUS_BADCMD = 0x02.
REQ-031 The block has no sub-modules; the top level pairs it with the existing UART rx/tx byte modules.

Verification
REQ-032 Cmd 0x83, data 0x5A, peripheral acks after 3 cycles -> one stb pulse with we=1, adr=3, dat=0x5A; tx byte 0x00.
REQ-033 Cmd 0x07, peripheral acks with dat=0xC4 -> stb with we=0, adr=7; tx bytes 0x00 then 0xC4.
REQ-034 Cmd 0x02, no ack, pTimeoutCycles=8 -> stb high exactly 8 cycles; tx bytes 0x01 then 0x00.
REQ-035 Cmd 0x30 -> no stb; tx byte 0x02; block back in Idle.
REQ-036 rx byte during Bus, with tx_ready held low 5 cycles -> rx_overrun = 1; tx_data stable through the stall; transaction completes normally.
REQ-037 rst low mid-Bus -> stb = 0 immediately; no tx byte after release; next command served normally.
